// File: rtl/load_mem_unit.sv
// Load unit: queues {tag, address} load requests, reads memory one at a time and broadcasts
// results on the CDB. Define LOAD_MEM_UNIT_STATS_EN to add the loadCount completion counter.
module load_mem_unit #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              requestEnable,
  input  logic [TAG_W-1:0]  requestRegister,
  input  logic [ADDR_W-1:0] requestAddress,
  output logic              requestReady,
  output logic              memRead,
  output logic [ADDR_W-1:0] memAddress,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic              cdbValid,
  output logic [TAG_W-1:0]  cdbTag,
  output logic [DATA_W-1:0] cdbData,
  input  logic              cdbGrant
`ifdef LOAD_MEM_UNIT_STATS_EN
  ,
  output logic [15:0]       loadCount
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StMem, StCdb} state_e;

  state_e            r_state;
  logic [TAG_W-1:0]  r_fifo_tag  [DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [TAG_W-1:0]  r_lat_tag;
  logic              r_mem_read;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);
  // Tag 0 means "no producer": the request is accepted but never queued.
  assign w_push  = requestEnable & ~w_full & (requestRegister != '0);
  // The head entry stays queued while its read is outstanding.
  assign w_pop   = (r_state == StMem) & memAck;

  assign requestReady = ~w_full;
  assign memRead      = r_mem_read;
  assign memAddress   = r_mem_addr;
  assign cdbValid     = r_cdb_valid;
  assign cdbTag       = r_cdb_tag;
  assign cdbData      = r_cdb_data;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_tag[r_wr_ptr]  <= requestRegister;
      r_fifo_addr[r_wr_ptr] <= requestAddress;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_lat_tag   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_empty) begin
            r_state    <= StMem;
            r_lat_tag  <= r_fifo_tag[r_rd_ptr];
            r_mem_addr <= r_fifo_addr[r_rd_ptr];
            r_mem_read <= 1'b1;
          end
        end
        StMem: begin
          if (memAck) begin
            r_state     <= StCdb;
            r_mem_read  <= 1'b0;
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_lat_tag;
            r_cdb_data  <= memData;
          end
        end
        StCdb: begin
          if (cdbGrant) begin
            r_state     <= StIdle;
            r_cdb_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_mem_read  <= 1'b0;
          r_cdb_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOAD_MEM_UNIT_STATS_EN
  logic [15:0] r_load_count;

  assign loadCount = r_load_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_load_count <= '0;
    end else if ((r_state == StCdb) && cdbGrant) begin
      r_load_count <= r_load_count + 16'd1;
    end
  end
`endif

endmodule
